// File: rtl/t9990_hscroll_ctl.sv
// Horizontal scroll / line-timing controller: dot-clock divider, fill/active/blank
// sequencing and fine-scroll buffer offset. Optional macro: T9990_HSCROLL_SHADOW_EN.
module t9990_hscroll_ctl #(
  parameter int DCLK_DIV = 4,
  parameter int H_ACTIVE = 256,
  parameter int PREFETCH = 32
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       HSYNC_START,
  input  logic       SCX_WE,
  input  logic [4:0] SCX,
  output logic       DCLK_EN,
  output logic [4:0] BUF_OFFSET,
  output logic       BUF_DISABLE,
  output logic       ACTIVE,
  output logic [8:0] DOT_X,
  output logic       LINE_START
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_BLANK  = 2'd3;

  localparam logic [3:0] DIV_LAST  = 4'(DCLK_DIV - 1);
  localparam logic [8:0] FILL_LAST = 9'(PREFETCH - 1);
  localparam logic [8:0] ACT_LAST  = 9'(H_ACTIVE - 1);
  // Truncation to 5 bits gives the mod-32 wrap of the buffer offset.
  localparam logic [4:0] OFF_BASE  = 5'(PREFETCH - 1);

  logic [3:0] div_cnt;
  logic [1:0] state;
  logic [8:0] dot_cnt;
  logic [4:0] scx_reg;
  logic [4:0] scx_eff;
  logic       buf_dis_r;
  logic       line_start_r;

  // Divider restarts on line start so the first dot lands DCLK_DIV cycles later.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n)                div_cnt <= '0;
    else if (HSYNC_START)        div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                         div_cnt <= div_cnt + 4'd1;
  end

  assign DCLK_EN = (div_cnt == DIV_LAST);

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state        <= S_IDLE;
      dot_cnt      <= '0;
      buf_dis_r    <= 1'b1;
      line_start_r <= 1'b0;
    end else if (HSYNC_START) begin
      state        <= S_FILL;
      dot_cnt      <= '0;
      buf_dis_r    <= 1'b0;
      line_start_r <= 1'b0;
    end else begin
      line_start_r <= 1'b0;
      case (state)
        S_FILL: if (DCLK_EN) begin
          if (dot_cnt == FILL_LAST) begin
            state        <= S_ACTIVE;
            dot_cnt      <= '0;
            line_start_r <= 1'b1;
          end else begin
            dot_cnt <= dot_cnt + 9'd1;
          end
        end
        S_ACTIVE: if (DCLK_EN) begin
          if (dot_cnt == ACT_LAST) begin
            state     <= S_BLANK;
            dot_cnt   <= '0;
            buf_dis_r <= 1'b1;
          end else begin
            dot_cnt <= dot_cnt + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n)    scx_reg <= '0;
    else if (SCX_WE) scx_reg <= SCX;
  end

`ifdef T9990_HSCROLL_SHADOW_EN
  logic [4:0] scx_shadow;
  // Latched at line start; a coincident write must win over the old register value.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n)         scx_shadow <= '0;
    else if (HSYNC_START) scx_shadow <= SCX_WE ? SCX : scx_reg;
  end
  assign scx_eff = scx_shadow;
`else
  assign scx_eff = scx_reg;
`endif

  assign BUF_OFFSET  = OFF_BASE - scx_eff;
  assign BUF_DISABLE = buf_dis_r;
  assign ACTIVE      = (state == S_ACTIVE);
  assign LINE_START  = line_start_r;
  assign DOT_X       = (state == S_ACTIVE) ? dot_cnt : 9'd0;

endmodule
